axis_serial_deserializer: RTL

Receives a frame-based serial bit stream that has already been brought into the local clock domain by the synchronizer stage, and recovers one DATA_WIDTH-bit word per frame. It sits directly downstream of the synchronizer in the SERDES receive path. It oversamples the line, validates the frame format and presents each word on an AXI-Stream master port through a 2-entry output buffer.

---
 rtl/axis_serial_deserializer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/axis_serial_deserializer.sv
// Oversampling serial frame receiver that delivers each recovered word through a 2-entry AXI-Stream buffer.
// Define DESER_PARITY_EN to expect an even-parity bit between the last data bit and the stop bit.
module axis_serial_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_serial,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic                  o_frame_err,
    output logic                  o_overflow,
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

`ifdef DESER_PARITY_EN
    // Even parity holds when data plus parity bit carry an even number of ones.
    function automatic logic even_parity_ok(input logic [DATA_WIDTH-1:0] data, input logic par);
        return ~((^data) ^ par);
    endfunction
`endif

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [BIT_W-1:0]        bit_idx_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic                    busy_r;
    logic                    frame_err_r;
`ifdef DESER_PARITY_EN
    logic                    parity_bit_r;
`endif

    logic [DATA_WIDTH-1:0]   head_r;
    logic [DATA_WIDTH-1:0]   tail_r;
    logic [1:0]              count_r;
    logic                    tvalid_r;
    logic                    overflow_r;

    logic                    tick_s;
    logic [DATA_WIDTH-1:0]   shift_next_s;
    logic                    parity_ok_s;
    logic                    push_s;
    logic                    pop_s;

    // Per-cycle decode: bit-period tick, next shift value, parity result and buffer handshakes.
    always_comb begin
        tick_s       = (cnt_r == FULL_LAST);
        shift_next_s = shift_r >> 1'b1;
        shift_next_s[DATA_WIDTH-1] = i_serial;
`ifdef DESER_PARITY_EN
        parity_ok_s  = even_parity_ok(shift_r, parity_bit_r);
`else
        parity_ok_s  = 1'b1;
`endif
        if ((state_r == ST_STOP) && tick_s && i_serial && parity_ok_s) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        pop_s = tvalid_r & i_tready;
    end

    // Frame receive FSM with its counters, shift register and registered status outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            bit_idx_r    <= '0;
            shift_r      <= '0;
            busy_r       <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef DESER_PARITY_EN
            parity_bit_r <= 1'b0;
`endif
        end else begin
            frame_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!i_serial) begin
                        state_r <= ST_START;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_START: begin
                    // Mid-bit check rejects short glitches without flagging an error.
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= '0;
                        if (i_serial) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= '0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        cnt_r   <= '0;
                        shift_r <= shift_next_s;
                        if (bit_idx_r == BIT_LAST) begin
`ifdef DESER_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + BIT_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
`ifdef DESER_PARITY_EN
                ST_PARITY: begin
                    if (tick_s) begin
                        cnt_r        <= '0;
                        parity_bit_r <= i_serial;
                        state_r      <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_s) begin
                        cnt_r <= '0;
                        if (i_serial && parity_ok_s) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (i_serial) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry output buffer: head_r is always the oldest word and drives o_tdata.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= 2'd0;
            tvalid_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        head_r   <= shift_r;
                        count_r  <= 2'd1;
                        tvalid_r <= 1'b1;
                    end
                end
                2'd1: begin
                    case ({push_s, pop_s})
                        2'b11: head_r <= shift_r;
                        2'b10: begin
                            tail_r  <= shift_r;
                            count_r <= 2'd2;
                        end
                        2'b01: begin
                            count_r  <= 2'd0;
                            tvalid_r <= 1'b0;
                        end
                        default: begin
                            count_r <= 2'd1;
                        end
                    endcase
                end
                2'd2: begin
                    case ({push_s, pop_s})
                        2'b11: begin
                            head_r <= tail_r;
                            tail_r <= shift_r;
                        end
                        2'b10: overflow_r <= 1'b1;
                        2'b01: begin
                            head_r  <= tail_r;
                            count_r <= 2'd1;
                        end
                        default: begin
                            count_r <= 2'd2;
                        end
                    endcase
                end
                default: begin
                    count_r  <= 2'd0;
                    tvalid_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_tdata     = head_r;
    assign o_tvalid    = tvalid_r;
    assign o_frame_err = frame_err_r;
    assign o_overflow  = overflow_r;
    assign o_busy      = busy_r;

endmodule
